// File: rtl/fmps_trip_scan.sv
// Sweeps the FMPS gatherer readout after each FA cycle; classifies nodes as tripped/missing and publishes bitmaps.
// Latency: bitmaps and resultStrobe N+2 cycles after the readoutValid rising edge (N = clamped scanCount).
// No backpressure: a readoutValid drop mid-sweep aborts it. FMPS_TRIP_SCAN_MISSING_TRIP_EN makes missing nodes count as trips.
module fmps_trip_scan #(
    parameter int INDEX_WIDTH      = 5,
    parameter int TRIP_FIELD_WIDTH = 16
) (
    input  logic                        sysClk,
    input  logic                        sysResetN,
    input  logic                        csrStrobe,
    input  logic [31:0]                 GPIO_OUT,
    input  logic                        readoutValid,
    output logic [INDEX_WIDTH-1:0]      fmpsReadoutAddress,
    input  logic [31:0]                 fmpsReadout,
    input  logic                        fmpsReadoutPresent,
    output logic [(1<<INDEX_WIDTH)-1:0] tripBitmap,
    output logic [(1<<INDEX_WIDTH)-1:0] missingBitmap,
    output logic [INDEX_WIDTH:0]        tripCount,
    output logic                        resultStrobe,
    output logic                        scanAbort,
    output logic                        mitigationTrip,
    output logic [31:0]                 csr
);
    localparam int NODES = 1 << INDEX_WIDTH;
    localparam int CW    = INDEX_WIDTH + 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(NODES);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

    state_t                      state_q, state_d;
    logic                        readout_vld_q;
    logic [CW-1:0]               ctl_count_q, ctl_count_d;
    logic [TRIP_FIELD_WIDTH-1:0] ctl_mask_q, ctl_mask_d;
    logic                        ctl_enable_q, ctl_enable_d;
    logic [CW-1:0]               sh_count_q, sh_count_d;
    logic [TRIP_FIELD_WIDTH-1:0] sh_mask_q, sh_mask_d;
    logic [INDEX_WIDTH-1:0]      addr_q, addr_d;
    logic [INDEX_WIDTH-1:0]      rd_idx_q, rd_idx_d;
    logic                        rd_vld_q, rd_vld_d;
    logic [NODES-1:0]            work_trip_q, work_trip_d;
    logic [NODES-1:0]            work_miss_q, work_miss_d;
    logic [CW-1:0]               work_cnt_q, work_cnt_d;
    logic [NODES-1:0]            trip_bmp_q, trip_bmp_d;
    logic [NODES-1:0]            miss_bmp_q, miss_bmp_d;
    logic [CW-1:0]               trip_cnt_q, trip_cnt_d;
    logic                        result_stb_q, result_stb_d;
    logic                        abort_stb_q, abort_stb_d;
    logic                        mit_q, mit_d;
    logic [5:0]                  abort_cnt_q, abort_cnt_d;
    logic [7:0]                  seq_q, seq_d;

    logic                        start;
    logic                        last_issue;
    logic [CW-1:0]               start_count;
    logic                        set_mit;
    logic                        do_abort;
    logic                        cls_miss, cls_trip;
    logic [NODES-1:0]            cls_sel;
    logic [NODES-1:0]            cls_trip_bmp, cls_miss_bmp;
    logic [CW-1:0]               cls_cnt;
    logic                        unused_inputs;

    assign start       = readoutValid && !readout_vld_q;
    assign start_count = (ctl_count_q > MAX_COUNT) ? MAX_COUNT : ctl_count_q;
    assign last_issue  = ({1'b0, addr_q} == (sh_count_q - CW'(1)));
    assign unused_inputs = ^{GPIO_OUT, fmpsReadout};

    // Data on the readout port belongs to the index issued in the previous cycle (rd_idx_q).
    always_comb begin
        cls_sel  = NODES'(1) << rd_idx_q;
        cls_miss = !fmpsReadoutPresent;
`ifdef FMPS_TRIP_SCAN_MISSING_TRIP_EN
        cls_trip = cls_miss || (|(fmpsReadout[TRIP_FIELD_WIDTH-1:0] & sh_mask_q));
`else
        cls_trip = !cls_miss && (|(fmpsReadout[TRIP_FIELD_WIDTH-1:0] & sh_mask_q));
`endif
        cls_trip_bmp = work_trip_q | (cls_trip ? cls_sel : '0);
        cls_miss_bmp = work_miss_q | (cls_miss ? cls_sel : '0);
        cls_cnt      = work_cnt_q + {{INDEX_WIDTH{1'b0}}, cls_trip};
    end

    always_comb begin
        state_d      = state_q;
        ctl_count_d  = ctl_count_q;
        ctl_mask_d   = ctl_mask_q;
        ctl_enable_d = ctl_enable_q;
        sh_count_d   = sh_count_q;
        sh_mask_d    = sh_mask_q;
        addr_d       = addr_q;
        rd_idx_d     = rd_idx_q;
        rd_vld_d     = 1'b0;
        work_trip_d  = work_trip_q;
        work_miss_d  = work_miss_q;
        work_cnt_d   = work_cnt_q;
        trip_bmp_d   = trip_bmp_q;
        miss_bmp_d   = miss_bmp_q;
        trip_cnt_d   = trip_cnt_q;
        result_stb_d = 1'b0;
        abort_stb_d  = 1'b0;
        mit_d        = mit_q;
        abort_cnt_d  = abort_cnt_q;
        seq_d        = seq_q;
        set_mit      = 1'b0;
        do_abort     = 1'b0;

        if (csrStrobe) begin
            ctl_count_d  = GPIO_OUT[INDEX_WIDTH:0];
            ctl_mask_d   = GPIO_OUT[8 +: TRIP_FIELD_WIDTH];
            ctl_enable_d = GPIO_OUT[31];
        end

        case (state_q)
            ST_IDLE: begin
                if (start && ctl_enable_q) begin
                    if (start_count == '0) begin
                        trip_bmp_d   = '0;
                        miss_bmp_d   = '0;
                        trip_cnt_d   = '0;
                        result_stb_d = 1'b1;
                        seq_d        = seq_q + 8'd1;
                    end else begin
                        state_d     = ST_SCAN;
                        addr_d      = '0;
                        sh_count_d  = start_count;
                        sh_mask_d   = ctl_mask_q;
                        work_trip_d = '0;
                        work_miss_d = '0;
                        work_cnt_d  = '0;
                    end
                end
            end
            ST_SCAN: begin
                if (!readoutValid) begin
                    do_abort = 1'b1;
                end else begin
                    if (rd_vld_q) begin
                        work_trip_d = cls_trip_bmp;
                        work_miss_d = cls_miss_bmp;
                        work_cnt_d  = cls_cnt;
                    end
                    rd_vld_d = 1'b1;
                    rd_idx_d = addr_q;
                    // Address holds on the last index so it never wraps past the clamp.
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + INDEX_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!readoutValid) begin
                    do_abort = 1'b1;
                end else begin
                    work_trip_d  = cls_trip_bmp;
                    work_miss_d  = cls_miss_bmp;
                    work_cnt_d   = cls_cnt;
                    trip_bmp_d   = cls_trip_bmp;
                    miss_bmp_d   = cls_miss_bmp;
                    trip_cnt_d   = cls_cnt;
                    result_stb_d = 1'b1;
                    seq_d        = seq_q + 8'd1;
                    set_mit      = |cls_trip_bmp;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                // Re-assert during DONE so a clear landing on the strobe cycle loses.
                set_mit = |trip_bmp_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_abort) begin
            state_d     = ST_IDLE;
            abort_stb_d = 1'b1;
            abort_cnt_d = (abort_cnt_q == 6'd63) ? abort_cnt_q : abort_cnt_q + 6'd1;
        end

        if (set_mit) begin
            mit_d = 1'b1;
        end else if (csrStrobe && GPIO_OUT[30]) begin
            mit_d = 1'b0;
        end
    end

    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            state_q       <= ST_IDLE;
            readout_vld_q <= 1'b0;
            ctl_count_q   <= '0;
            ctl_mask_q    <= '0;
            ctl_enable_q  <= 1'b0;
            sh_count_q    <= '0;
            sh_mask_q     <= '0;
            addr_q        <= '0;
            rd_idx_q      <= '0;
            rd_vld_q      <= 1'b0;
            work_trip_q   <= '0;
            work_miss_q   <= '0;
            work_cnt_q    <= '0;
            trip_bmp_q    <= '0;
            miss_bmp_q    <= '0;
            trip_cnt_q    <= '0;
            result_stb_q  <= 1'b0;
            abort_stb_q   <= 1'b0;
            mit_q         <= 1'b0;
            abort_cnt_q   <= '0;
            seq_q         <= '0;
        end else begin
            state_q       <= state_d;
            readout_vld_q <= readoutValid;
            ctl_count_q   <= ctl_count_d;
            ctl_mask_q    <= ctl_mask_d;
            ctl_enable_q  <= ctl_enable_d;
            sh_count_q    <= sh_count_d;
            sh_mask_q     <= sh_mask_d;
            addr_q        <= addr_d;
            rd_idx_q      <= rd_idx_d;
            rd_vld_q      <= rd_vld_d;
            work_trip_q   <= work_trip_d;
            work_miss_q   <= work_miss_d;
            work_cnt_q    <= work_cnt_d;
            trip_bmp_q    <= trip_bmp_d;
            miss_bmp_q    <= miss_bmp_d;
            trip_cnt_q    <= trip_cnt_d;
            result_stb_q  <= result_stb_d;
            abort_stb_q   <= abort_stb_d;
            mit_q         <= mit_d;
            abort_cnt_q   <= abort_cnt_d;
            seq_q         <= seq_d;
        end
    end

    always_comb begin
        csr                = '0;
        csr[31]            = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
        csr[30]            = mit_q;
        csr[29:24]         = abort_cnt_q;
        csr[23:16]         = seq_q;
        csr[INDEX_WIDTH:0] = trip_cnt_q;
    end

    assign fmpsReadoutAddress = addr_q;
    assign tripBitmap         = trip_bmp_q;
    assign missingBitmap      = miss_bmp_q;
    assign tripCount          = trip_cnt_q;
    assign resultStrobe       = result_stb_q;
    assign scanAbort          = abort_stb_q;
    assign mitigationTrip     = mit_q;

endmodule

// File: tb/tb_fmps_trip_scan.sv
// Scoreboarded bench for fmps_trip_scan: stimulus pushes expected results, a monitor checks each strobe.
module tb_fmps_trip_scan;
    localparam int IW  = 5;
    localparam int TFW = 16;
    localparam int NN  = 1 << IW;

    logic          sysClk;
    logic          sysResetN;
    logic          csrStrobe;
    logic [31:0]   GPIO_OUT;
    logic          readoutValid;
    logic [IW-1:0] fmpsReadoutAddress;
    logic [31:0]   fmpsReadout;
    logic          fmpsReadoutPresent;
    logic [NN-1:0] tripBitmap;
    logic [NN-1:0] missingBitmap;
    logic [IW:0]   tripCount;
    logic          resultStrobe;
    logic          scanAbort;
    logic          mitigationTrip;
    logic [31:0]   csr;

    fmps_trip_scan #(.INDEX_WIDTH(IW), .TRIP_FIELD_WIDTH(TFW)) dut (
        .sysClk(sysClk), .sysResetN(sysResetN), .csrStrobe(csrStrobe), .GPIO_OUT(GPIO_OUT),
        .readoutValid(readoutValid), .fmpsReadoutAddress(fmpsReadoutAddress),
        .fmpsReadout(fmpsReadout), .fmpsReadoutPresent(fmpsReadoutPresent),
        .tripBitmap(tripBitmap), .missingBitmap(missingBitmap), .tripCount(tripCount),
        .resultStrobe(resultStrobe), .scanAbort(scanAbort), .mitigationTrip(mitigationTrip),
        .csr(csr)
    );

    typedef struct {
        bit          is_abort;
        int          cyc;
        logic [31:0] trip;
        logic [31:0] miss;
        int          cnt;
        bit          mit;
        int          aborts;
        int          seq;
        bit          chk_seen;
        logic [31:0] seen;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    logic [31:0] node_data [NN];
    bit          node_pres [NN];
    logic [IW-1:0] prev_addr;
    logic [31:0] seen_mask;

    // Reference model state
    int          ctl_count;
    logic [15:0] ctl_mask;
    bit          ctl_en;
    logic [31:0] m_trip, m_miss;
    int          m_cnt, m_aborts, m_seq;
    bit          m_mit;

    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    initial forever begin
        @(posedge sysClk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got cycle %0d, expected completion well before that", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Gatherer model: data for the address driven in one cycle appears in the next.
    initial begin
        prev_addr = '0;
        seen_mask = '0;
        fmpsReadout = '0;
        fmpsReadoutPresent = 1'b0;
        forever begin
            @(negedge sysClk);
            fmpsReadout        = node_data[prev_addr];
            fmpsReadoutPresent = node_pres[prev_addr];
            if (csr[31]) seen_mask[fmpsReadoutAddress] = 1'b1;
            prev_addr = fmpsReadoutAddress;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge sysClk);
            if (sysResetN && (resultStrobe || scanAbort)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {62'd0, resultStrobe, scanAbort}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {62'd0, resultStrobe, scanAbort}, e.is_abort ? 64'd1 : 64'd2);
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("tripBitmap", tripBitmap, e.trip);
                    chk("missingBitmap", missingBitmap, e.miss);
                    chk("tripCount", tripCount, e.cnt);
                    chk("mitigationTrip", mitigationTrip, e.mit);
                    chk("csr_abort_count", csr[29:24], e.aborts);
                    chk("csr_seq", csr[23:16], e.seq);
                    chk("csr_tripcount", csr[IW:0], e.cnt);
                    if (e.chk_seen) chk("addr_coverage", seen_mask, e.seen);
                end
            end
        end
    end

    function automatic void model_scan(input int n, input logic [15:0] mask,
                                       output logic [31:0] trip, output logic [31:0] miss,
                                       output int cnt);
        bit t;
        trip = '0;
        miss = '0;
        cnt  = 0;
        for (int i = 0; i < n; i++) begin
            t = 1'b0;
            if (!node_pres[i]) begin
                miss[i] = 1'b1;
`ifdef FMPS_TRIP_SCAN_MISSING_TRIP_EN
                t = 1'b1;
`endif
            end else if ((node_data[i][15:0] & mask) != 16'd0) begin
                t = 1'b1;
            end
            if (t) begin
                trip[i] = 1'b1;
                cnt++;
            end
        end
    endfunction

    task automatic model_reset();
        ctl_count = 0; ctl_mask = '0; ctl_en = 1'b0;
        m_trip = '0; m_miss = '0; m_cnt = 0; m_aborts = 0; m_seq = 0; m_mit = 1'b0;
    endtask

    task automatic push_exp(input bit ab, input int cy, input bit cs, input logic [31:0] seen);
        exp_t e;
        e.is_abort = ab; e.cyc = cy; e.trip = m_trip; e.miss = m_miss; e.cnt = m_cnt;
        e.mit = m_mit; e.aborts = m_aborts; e.seq = m_seq; e.chk_seen = cs; e.seen = seen;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge sysClk);
    endtask

    task automatic csr_write(input int count, input logic [15:0] mask, input bit clr, input bit en);
        logic [5:0] c6;
        c6 = count[5:0];
        GPIO_OUT  = {en, clr, 6'd0, mask, 2'd0, c6};
        csrStrobe = 1'b1;
        @(negedge sysClk);
        csrStrobe = 1'b0;
        GPIO_OUT  = '0;
        ctl_count = count & 63;
        ctl_mask  = mask;
        ctl_en    = en;
        if (clr) m_mit = 1'b0;
    endtask

    task automatic clear_nodes();
        for (int i = 0; i < NN; i++) begin
            node_data[i] = '0;
            node_pres[i] = 1'b1;
        end
    endtask

    task automatic rand_nodes();
        logic [31:0] r;
        for (int i = 0; i < NN; i++) begin
            r = $urandom();
            node_pres[i] = ($urandom_range(0, 9) != 0);
            node_data[i] = ($urandom_range(0, 2) == 0) ? r : (r & 32'hFFFF_0000);
        end
    endtask

    // Called at a negedge with readoutValid low for at least one clock.
    task automatic run_scan(input int abort_at, input bit clr_at_done);
        int          c, eff, cnt;
        logic [31:0] trip, miss, seen;
        logic [5:0]  c6;
        c   = cyc;
        eff = (ctl_count > NN) ? NN : ctl_count;
        seen_mask    = '0;
        readoutValid = 1'b1;
        if (!ctl_en) begin
            wait_until(c + 6);
        end else if (eff == 0) begin
            m_trip = '0; m_miss = '0; m_cnt = 0; m_seq = (m_seq + 1) % 256;
            push_exp(1'b0, c + 1, 1'b0, '0);
            wait_until(c + 3);
        end else if (abort_at > 0 && abort_at <= eff + 1) begin
            m_aborts = (m_aborts < 63) ? m_aborts + 1 : 63;
            push_exp(1'b1, c + abort_at + 1, 1'b0, '0);
            wait_until(c + abort_at);
            readoutValid = 1'b0;
            wait_until(c + abort_at + 3);
        end else begin
            model_scan(eff, ctl_mask, trip, miss, cnt);
            m_trip = trip; m_miss = miss; m_cnt = cnt; m_seq = (m_seq + 1) % 256;
            if (trip != 0) m_mit = 1'b1;
            seen = (eff == 32) ? 32'hFFFF_FFFF : ((32'd1 << eff) - 32'd1);
            push_exp(1'b0, c + eff + 2, 1'b1, seen);
            if (clr_at_done) begin
                wait_until(c + eff + 2);
                c6 = ctl_count[5:0];
                GPIO_OUT  = {ctl_en, 1'b1, 6'd0, ctl_mask, 2'd0, c6};
                csrStrobe = 1'b1;
                @(negedge sysClk);
                csrStrobe = 1'b0;
                GPIO_OUT  = '0;
                if (trip == 0) m_mit = 1'b0;
            end
            wait_until(c + eff + 4);
        end
        readoutValid = 1'b0;
        @(negedge sysClk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tripBitmap"}, tripBitmap, 0);
        chk({tag, "_missingBitmap"}, missingBitmap, 0);
        chk({tag, "_tripCount"}, tripCount, 0);
        chk({tag, "_resultStrobe"}, resultStrobe, 0);
        chk({tag, "_scanAbort"}, scanAbort, 0);
        chk({tag, "_mitigationTrip"}, mitigationTrip, 0);
        chk({tag, "_csr"}, csr, 0);
        chk({tag, "_address"}, fmpsReadoutAddress, 0);
    endtask

    initial begin
        int          cnt_r, eff, ab, tgt;
        logic [15:0] mk;
        bit          clr, en;

        sysResetN = 1'b0; csrStrobe = 1'b0; GPIO_OUT = '0; readoutValid = 1'b0;
        clear_nodes();
        model_reset();
        repeat (3) @(negedge sysClk);
        check_all_zero("reset");
        sysResetN = 1'b1;
        @(negedge sysClk);

        // Three nodes, node 1 trips on bit 0
        node_data[1] = 32'h0000_0001;
        csr_write(3, 16'h0001, 1'b0, 1'b1);
        run_scan(0, 1'b0);
        csr_write(3, 16'h0001, 1'b1, 1'b1);
        chk("clear_only_mit", mitigationTrip, m_mit);

        // Mask excludes node 0's bit; node 2 absent
        clear_nodes();
        node_data[0] = 32'h0000_0001;
        node_pres[2] = 1'b0;
        csr_write(3, 16'h0002, 1'b0, 1'b1);
        run_scan(0, 1'b0);

        // Abort mid-scan keeps the previous bitmaps
        rand_nodes();
        csr_write(8, 16'hFFFF, 1'b0, 1'b1);
        run_scan(4, 1'b0);

        // Clear landing on the tripping result strobe
        clear_nodes();
        node_data[1] = 32'h0000_0001;
        csr_write(3, 16'h0001, 1'b1, 1'b1);
        run_scan(0, 1'b1);
        chk("collision_mit", mitigationTrip, m_mit);
        csr_write(3, 16'h0001, 1'b1, 1'b1);
        chk("late_clear_mit", mitigationTrip, m_mit);

        // Zero-length scan
        csr_write(0, 16'h0001, 1'b0, 1'b1);
        run_scan(0, 1'b0);

        // Clamp: 40 requested, 32 scanned
        rand_nodes();
        mk = 16'($urandom());
        csr_write(40, mk, 1'b0, 1'b1);
        run_scan(0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            rand_nodes();
            cnt_r = $urandom_range(0, 45);
            mk    = 16'($urandom());
            clr   = ($urandom_range(0, 3) == 0);
            en    = ($urandom_range(0, 7) != 0);
            csr_write(cnt_r, mk, clr, en);
            eff = (cnt_r > NN) ? NN : cnt_r;
            ab  = (eff > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, eff + 1) : 0;
            run_scan(ab, 1'b0);
        end

        // Reset asserted mid-scan
        rand_nodes();
        csr_write(8, 16'hFFFF, 1'b0, 1'b1);
        readoutValid = 1'b1;
        tgt = cyc + 4;
        wait_until(tgt);
        chk("midscan_scanning", csr[31], 1);
        sysResetN = 1'b0;
        #1;
        check_all_zero("midscan_reset");
        model_reset();
        @(negedge sysClk);
        sysResetN    = 1'b1;
        readoutValid = 1'b0;
        @(negedge sysClk);
        readoutValid = 1'b1;
        repeat (10) @(negedge sysClk);
        chk("post_reset_scanning", csr[31], 0);
        chk("post_reset_address", fmpsReadoutAddress, 0);
        readoutValid = 1'b0;
        @(negedge sysClk);
        clear_nodes();
        node_data[2] = 32'h0000_0100;
        csr_write(3, 16'h0100, 1'b0, 1'b1);
        run_scan(0, 1'b0);

        repeat (5) @(negedge sysClk);
        chk("pending_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
